// File: rtl/exec_ctrl.sv
// Execution control front-end for the kappa3-light phase generator.
// Debounces the three board buttons into single-cycle events, issues
// run / step_inst / step_phase pulses, and stops a free-running program
// when the fetch PC matches the hardware breakpoint.
module exec_ctrl #(
  parameter int unsigned DEBOUNCE = 250000,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                btn_run,
  input  logic                btn_step_inst,
  input  logic                btn_step_phase,
  input  logic [3:0]          cstate,
  input  logic                running,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] bp_addr,
  input  logic                bp_en,
  output logic                run,
  output logic                step_inst,
  output logic                step_phase,
  output logic                bp_hit,
  output logic [2:0]          ctl_state
);

  // Counter runs 0..DEBOUNCE-1; reaching the top means DEBOUNCE differing cycles.
  localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StStartWait = 3'd1,
    StSkip      = 3'd2,
    StWatch     = 3'd3,
    StStopWait  = 3'd4,
    StStepWait  = 3'd5,
    StStepEnd   = 3'd6
  } state_e;

  // Button index: 0 run, 1 step_inst, 2 step_phase.
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q;
  logic [2:0]      sync2_q;
  logic [2:0]      db_q;
  logic [2:0]      evt_q;
  logic [CntW-1:0] cnt_q [3];

  logic            run_evt;
  logic            inst_evt;
  logic            phase_evt;
  logic            bp_stop;

  state_e          state_q;
  logic            run_q;
  logic            step_inst_q;
  logic            step_phase_q;
  logic            bp_hit_q;

  assign btn_raw = {btn_step_phase, btn_step_inst, btn_run};

  // Synchronize, debounce and edge-detect all three buttons.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      evt_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        evt_q[i] <= 1'b0;
        if (sync2_q[i] == db_q[i]) begin
          // Level agrees with the accepted value: any bounce restarts the count.
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          cnt_q[i] <= '0;
          db_q[i]  <= sync2_q[i];
          // Strobe only on press; release is silent.
          evt_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Same-cycle priority: run beats step_inst beats step_phase.
  assign run_evt   = evt_q[0];
  assign inst_evt  = evt_q[1] & ~evt_q[0];
  assign phase_evt = evt_q[2] & ~evt_q[1] & ~evt_q[0];

  // Combinational so the phase generator sees run on the edge that ends this IF.
  assign bp_stop = bp_en & (state_q == StWatch) & (cstate == 4'b0001) & (pc == bp_addr);

  // Control FSM with registered command pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      run_q        <= 1'b0;
      step_inst_q  <= 1'b0;
      step_phase_q <= 1'b0;
      bp_hit_q     <= 1'b0;
    end else begin
      run_q        <= 1'b0;
      step_inst_q  <= 1'b0;
      step_phase_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run_evt) begin
            run_q    <= 1'b1;
            bp_hit_q <= 1'b0;
            state_q  <= StStartWait;
          end else if (inst_evt) begin
            step_inst_q <= 1'b1;
            bp_hit_q    <= 1'b0;
            state_q     <= StStepWait;
          end else if (phase_evt) begin
            step_phase_q <= 1'b1;
            bp_hit_q     <= 1'b0;
            state_q      <= StStepWait;
          end
        end
        StStartWait: begin
          if (running) state_q <= StSkip;
        end
        StSkip: begin
          // Let the first IF pass so a run started on the breakpoint PC proceeds.
          if (run_evt) begin
            run_q   <= 1'b1;
            state_q <= StStopWait;
          end else if (!cstate[0]) begin
            state_q <= StWatch;
          end
        end
        StWatch: begin
          if (bp_stop) begin
            // A coincident user stop is absorbed into this single pulse.
            bp_hit_q <= 1'b1;
            state_q  <= StStopWait;
          end else if (run_evt) begin
            run_q   <= 1'b1;
            state_q <= StStopWait;
          end else if (!running) begin
            state_q <= StIdle;
          end
        end
        StStopWait: begin
          if (!running) state_q <= StIdle;
        end
        StStepWait: begin
          if (running) state_q <= StStepEnd;
        end
        StStepEnd: begin
          if (!running) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign run        = run_q | bp_stop;
  assign step_inst  = step_inst_q;
  assign step_phase = step_phase_q;
  assign bp_hit     = bp_hit_q;
  assign ctl_state  = state_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: a small phase-generator model reacts to the command
// pulses, a history-window debounce model predicts button events, and
// directed steps with randomized parameters check the control behaviour.
module tb_exec_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned PW  = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    btn   = '0;
  logic [3:0]    cstate;
  logic          running;
  logic [PW-1:0] pc;
  logic [PW-1:0] bp_addr = '0;
  logic          bp_en   = 1'b0;
  logic          run;
  logic          step_inst;
  logic          step_phase;
  logic          bp_hit;
  logic [2:0]    ctl_state;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clock = ~clock;

  exec_ctrl #(
    .DEBOUNCE(DEB),
    .PC_WIDTH(PW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_run       (btn[0]),
    .btn_step_inst (btn[1]),
    .btn_step_phase(btn[2]),
    .cstate        (cstate),
    .running       (running),
    .pc            (pc),
    .bp_addr       (bp_addr),
    .bp_en         (bp_en),
    .run           (run),
    .step_inst     (step_inst),
    .step_phase    (step_phase),
    .bp_hit        (bp_hit),
    .ctl_state     (ctl_state)
  );

  // Phase generator model: IF/DE/EX/WB, pc loops over loop_len instructions.
  logic [PW-1:0] pc_init  = '0;
  int unsigned   loop_len = 64;
  logic [1:0]    pg_phase;
  logic          pg_run;
  logic          pg_free;
  logic          pg_stop_pend;
  logic [2:0]    pg_left;
  logic [PW-1:0] pg_pc;
  int unsigned   pg_instr;

  assign cstate  = 4'b0001 << pg_phase;
  assign running = pg_run;
  assign pc      = pg_pc;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pg_phase <= 2'd0; pg_run <= 1'b0; pg_free <= 1'b0; pg_stop_pend <= 1'b0;
      pg_left <= 3'd0; pg_pc <= pc_init; pg_instr <= 0;
    end else if (!pg_run) begin
      pg_stop_pend <= 1'b0;
      if (run) begin
        pg_run <= 1'b1; pg_free <= 1'b1;
      end else if (step_inst) begin
        pg_run <= 1'b1; pg_free <= 1'b0; pg_left <= 3'd4;
      end else if (step_phase) begin
        pg_run <= 1'b1; pg_free <= 1'b0; pg_left <= 3'd1;
      end
    end else if (pg_free && pg_phase == 2'd0 && (run || pg_stop_pend)) begin
      pg_run <= 1'b0; pg_stop_pend <= 1'b0;
    end else begin
      if (run) pg_stop_pend <= 1'b1;
      pg_phase <= pg_phase + 2'd1;
      if (pg_phase == 2'd3) begin
        pg_instr <= pg_instr + 1;
        pg_pc <= (pg_pc + 32'd4 >= pc_init + loop_len * 4) ? pc_init : pg_pc + 32'd4;
      end
      if (!pg_free) begin
        pg_left <= pg_left - 3'd1;
        if (pg_left == 3'd1) pg_run <= 1'b0;
      end
    end
  end

  // Debounce reference (stable-window view) plus output monitor.
  int unsigned   cyc = 0;
  logic [DEB+1:0] hist [3];
  logic [2:0]    m_db = '0;
  int unsigned   m_evt_cyc [3];
  int unsigned   n_run = 0, n_si = 0, n_sp = 0, viol = 0;
  int unsigned   last_run_cyc = 0;
  logic [PW-1:0] last_run_pc = '0;
  logic [3:0]    last_run_cs = '0;
  logic          p_run = 1'b0, p_si = 1'b0, p_sp = 1'b0;
  logic [2:0]    last_st = 3'd0;
  logic [2:0]    st_log [$];

  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      for (int b = 0; b < 3; b++) hist[b] = '0;
      m_db = '0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        hist[b] = {hist[b][DEB:0], btn[b]};
        // Synchronized level seen by the debouncer lags the pin by two edges.
        if (hist[b][DEB+1:2] == {DEB{~m_db[b]}}) begin
          m_db[b] = ~m_db[b];
          if (m_db[b]) m_evt_cyc[b] = cyc;
        end
      end
    end
    #1;
    if (run) begin
      n_run++; last_run_cyc = cyc; last_run_pc = pc; last_run_cs = cstate;
    end
    if (step_inst) n_si++;
    if (step_phase) n_sp++;
    if (int'(run) + int'(step_inst) + int'(step_phase) > 1) viol++;
    if ((run && p_run) || (step_inst && p_si) || (step_phase && p_sp)) viol++;
    p_run = run; p_si = step_inst; p_sp = step_phase;
    if (ctl_state != last_st) begin
      st_log.push_back(ctl_state);
      last_st = ctl_state;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic press(input int b, input int glitches);
    for (int g = 0; g < glitches; g++) begin
      btn[b] = 1'b1; tick($urandom_range(1, 3));
      btn[b] = 1'b0; tick($urandom_range(1, 2));
    end
    btn[b] = 1'b1; tick(10);
    btn[b] = 1'b0; tick(10);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int i;
    i = 0;
    while (ctl_state !== st && i < budget) begin
      tick(1);
      i++;
    end
    check(tag, ctl_state, st);
  endtask

  function automatic logic [8:0] seq3(input int unsigned base);
    if (st_log.size() < base + 3) return 9'h1ff;
    return {st_log[base], st_log[base+1], st_log[base+2]};
  endfunction

  initial begin
    int unsigned b_run, b_si, b_sp, b_st, s, nins;
    int i;

    tick(3);
    check("reset_ctl_state", ctl_state, 3'd0);
    check("reset_outputs", {run, step_inst, step_phase, bp_hit}, 4'b0);
    reset = 1'b1;
    tick(2);

    // Glitchy run press, then user stop.
    b_run = n_run; b_st = st_log.size();
    for (int g = 0; g < 2 + $urandom_range(0, 2); g++) begin
      btn[0] = 1'b1; tick($urandom_range(1, 3));
      btn[0] = 1'b0; tick($urandom_range(1, 2));
    end
    btn[0] = 1'b1; s = cyc + 1; tick(10);
    btn[0] = 1'b0; tick(10);
    check("A_run_pulses", n_run - b_run, 1);
    check("A_pulse_vs_model", last_run_cyc, m_evt_cyc[0] + 1);
    check("A_pulse_latency", last_run_cyc - s, 6);
    check("A_state_seq", seq3(b_st), {3'd1, 3'd2, 3'd3});
    check("A_watch", ctl_state, 3'd3);
    press(0, 0);
    wait_state(3'd0, 50, "A_stop_idle");
    check("A_stop_pulses", n_run - b_run, 2);
    check("A_no_bp_hit", bp_hit, 1'b0);
    check("A_stopped_at_if", {running, cstate}, {1'b0, 4'b0001});

    // All three buttons together: only run survives.
    b_run = n_run; b_si = n_si; b_sp = n_sp;
    btn = 3'b111; tick(10);
    btn = 3'b000; tick(10);
    check("P_run_pulse", n_run - b_run, 1);
    check("P_steps_dropped", (n_si - b_si) + (n_sp - b_sp), 0);
    press(0, 0);
    wait_state(3'd0, 50, "P_idle");

    // Breakpoint stop: first at 0x10 from 0, then random placements.
    for (int r = 0; r < 4; r++) begin
      pc_init  = (r == 0) ? 32'h0 : 32'(4 * $urandom_range(0, 15));
      nins     = (r == 0) ? 4 : $urandom_range(1, 8);
      bp_addr  = pc_init + 32'(4 * nins);
      bp_en    = 1'b1;
      loop_len = 64;
      do_reset();
      b_run = n_run;
      press(0, $urandom_range(0, 2));
      wait_state(3'd0, 200, "B_idle");
      check("B_pulses", n_run - b_run, 2);
      check("B_stop_at_bp", {last_run_pc, last_run_cs}, {bp_addr, 4'b0001});
      check("B_instr_count", pg_instr, nins);
      check("B_bp_hit", bp_hit, 1'b1);
      check("B_halted", {running, pc}, {1'b0, bp_addr});
    end

    // Run started on the breakpoint PC inside a 3-instruction loop.
    pc_init = 32'h20; bp_addr = 32'h20; loop_len = 3;
    do_reset();
    b_run = n_run;
    press(0, 0);
    wait_state(3'd0, 200, "C_idle");
    check("C_instr_count", pg_instr, 3);
    check("C_pulses", n_run - b_run, 2);
    check("C_stop_pc", last_run_pc, 32'h20);
    check("C_bp_hit", bp_hit, 1'b1);

    // step_inst, with step_phase pressed one cycle later (must be dropped).
    b_si = n_si; b_sp = n_sp; b_st = st_log.size(); nins = pg_instr;
    btn[1] = 1'b1; tick(1);
    btn[2] = 1'b1; tick(10);
    btn = 3'b000; tick(10);
    check("D_step_inst", n_si - b_si, 1);
    check("D_phase_dropped", n_sp - b_sp, 0);
    check("D_bp_hit_clear", bp_hit, 1'b0);
    check("D_one_instr", pg_instr - nins, 1);
    check("D_state_seq", seq3(b_st), {3'd5, 3'd6, 3'd0});
    check("D_runs_none", n_run - b_run, 2);

    // step_phase alone advances exactly one phase.
    b_si = n_si; b_sp = n_sp;
    press(2, 1);
    check("D2_step_phase", n_sp - b_sp, 1);
    check("D2_no_step_inst", n_si - b_si, 0);
    check("D2_phase_de", cstate, 4'b0010);
    check("D2_idle", ctl_state, 3'd0);

    // User stop lands in the same cycle as the breakpoint.
    pc_init = 32'h40; bp_addr = 32'h40; loop_len = 1; bp_en = 1'b0;
    do_reset();
    b_run = n_run;
    btn[0] = 1'b1; tick(10);
    btn[0] = 1'b0; tick(10);
    wait_state(3'd3, 50, "E_watch");
    i = 0;
    while (cstate !== 4'b0001 && i < 8) begin
      tick(1);
      i++;
    end
    // Event strobe arrives 8 cycles after this IF, which is again an IF.
    tick(2);
    btn[0] = 1'b1; tick(5);
    bp_en = 1'b1; tick(3);
    btn[0] = 1'b0; tick(10);
    wait_state(3'd0, 50, "E_idle");
    check("E_pulses", n_run - b_run, 2);
    check("E_coincide", last_run_cyc, m_evt_cyc[0]);
    check("E_bp_hit", bp_hit, 1'b1);

    // Asynchronous reset in WATCH, then a normal restart.
    bp_en = 1'b0; pc_init = 32'h0; loop_len = 64;
    do_reset();
    press(0, 0);
    wait_state(3'd3, 50, "F_watch");
    #2 reset = 1'b0;
    #1;
    check("F_async_outputs", {run, step_inst, step_phase, bp_hit}, 4'b0);
    check("F_async_state", ctl_state, 3'd0);
    tick(2);
    reset = 1'b1;
    tick(2);
    b_run = n_run;
    press(0, 1);
    check("F_restart_pulse", n_run - b_run, 1);
    check("F_restart_watch", ctl_state, 3'd3);

    check("pulse_shape", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
